parking_lot_ctrl: RTL

- Parametrised, fully synchronous successor of the two-class (university/general) parking counter.
- Keeps a time-of-day clock and derives a per-hour general/university capacity split from it.
- Arbitrates entry and exit requests with single-cycle grant/deny responses and publishes occupancy, free-space and overflow status.
- Sits between the gate sensors and the display/gate-actuator logic.

---
 rtl/parking_lot_ctrl_if.sv | 40 ++++
 rtl/parking_lot_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/parking_lot_ctrl_if.sv
// Gate-side bundle for the parking lot controller: requests from the
// sensors and registered responses/status toward display and actuators.
interface parking_lot_ctrl_if #(
    parameter int CNT_W = 11
);
    logic             entry_req;
    logic             entry_is_uni;
    logic             exit_req;
    logic             exit_is_uni;
    logic             time_load;
    logic [4:0]       hour_in;
    logic             entry_grant;
    logic             entry_deny;
    logic             exit_ack;
    logic             exit_err;
    logic [CNT_W-1:0] uni_parked;
    logic [CNT_W-1:0] gen_parked;
    logic [CNT_W-1:0] uni_free;
    logic [CNT_W-1:0] gen_free;
    logic             uni_has_space;
    logic             gen_has_space;
    logic             over_capacity;
    logic [4:0]       hour;

    modport master (
        output entry_req, entry_is_uni, exit_req, exit_is_uni,
        output time_load, hour_in,
        input  entry_grant, entry_deny, exit_ack, exit_err,
        input  uni_parked, gen_parked, uni_free, gen_free,
        input  uni_has_space, gen_has_space, over_capacity, hour
    );

    modport slave (
        input  entry_req, entry_is_uni, exit_req, exit_is_uni,
        input  time_load, hour_in,
        output entry_grant, entry_deny, exit_ack, exit_err,
        output uni_parked, gen_parked, uni_free, gen_free,
        output uni_has_space, gen_has_space, over_capacity, hour
    );
endinterface

// File: rtl/parking_lot_ctrl.sv
// Two-class parking counter with a time-of-day driven capacity split
// and single-cycle registered entry/exit arbitration.
module parking_lot_ctrl #(
    parameter int TOTAL_SPACES   = 700,
    parameter int GEN_DAY_CAP    = 200,
    parameter int RAMP_STEP      = 50,
    parameter int GEN_NIGHT_CAP  = 500,
    parameter int TICKS_PER_HOUR = 600,
    parameter int START_HOUR     = 0,
    parameter int CNT_W          = 11
) (
    input logic clk,
    input logic rst,
    parking_lot_ctrl_if.slave bus
);
    typedef logic [CNT_W-1:0] cnt_t;

    localparam int TW = (TICKS_PER_HOUR > 1) ? $clog2(TICKS_PER_HOUR) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_HOUR - 1);

    function automatic cnt_t sched(input logic [4:0] h);
        int c;
        if (h >= 5'd8 && h <= 5'd12)
            c = GEN_DAY_CAP;
        else if (h >= 5'd13 && h <= 5'd15)
            c = GEN_DAY_CAP + (int'(h) - 12) * RAMP_STEP;
        else
            c = GEN_NIGHT_CAP;
        return cnt_t'(c);
    endfunction

    localparam logic [4:0] START_H = 5'(START_HOUR);
    localparam cnt_t TOT = cnt_t'(TOTAL_SPACES);
    localparam cnt_t START_GEN = sched(START_H);

    logic [TW-1:0] r_tick, w_tick_nxt;
    logic [4:0]    r_hour, w_hour_nxt;
    cnt_t          r_gen_cap, r_uni_cap;
    cnt_t          r_gen, r_uni, w_gen_nxt, w_uni_nxt;
    cnt_t          w_en_cap, w_en_cnt, w_ex_cnt;
    logic          w_grant, w_deny, w_ack, w_err;
    logic          r_grant, r_deny, r_ack, r_err;

    always_comb begin
        w_tick_nxt = r_tick + TW'(1);
        w_hour_nxt = r_hour;
        if (bus.time_load) begin
            w_tick_nxt = '0;
            if (bus.hour_in <= 5'd23)
                w_hour_nxt = bus.hour_in;
        end else if (r_tick == TICK_MAX) begin
            w_tick_nxt = '0;
            w_hour_nxt = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
        end
    end

    // Entry is judged on pre-update counts, so a same-cycle exit never helps it.
    always_comb begin
        w_en_cap  = bus.entry_is_uni ? r_uni_cap : r_gen_cap;
        w_en_cnt  = bus.entry_is_uni ? r_uni : r_gen;
        w_ex_cnt  = bus.exit_is_uni ? r_uni : r_gen;
        w_grant   = bus.entry_req && (w_en_cnt < w_en_cap);
        w_deny    = bus.entry_req && !(w_en_cnt < w_en_cap);
        w_ack     = bus.exit_req && (w_ex_cnt != '0);
        w_err     = bus.exit_req && (w_ex_cnt == '0);
        w_uni_nxt = r_uni + cnt_t'(w_grant && bus.entry_is_uni)
                          - cnt_t'(w_ack && bus.exit_is_uni);
        w_gen_nxt = r_gen + cnt_t'(w_grant && !bus.entry_is_uni)
                          - cnt_t'(w_ack && !bus.exit_is_uni);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick    <= '0;
            r_hour    <= START_H;
            r_gen_cap <= START_GEN;
            r_uni_cap <= TOT - START_GEN;
            r_gen     <= '0;
            r_uni     <= '0;
            r_grant   <= 1'b0;
            r_deny    <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_tick    <= w_tick_nxt;
            r_hour    <= w_hour_nxt;
            r_gen_cap <= sched(r_hour);
            r_uni_cap <= TOT - sched(r_hour);
            r_gen     <= w_gen_nxt;
            r_uni     <= w_uni_nxt;
            r_grant   <= w_grant;
            r_deny    <= w_deny;
            r_ack     <= w_ack;
            r_err     <= w_err;
        end
    end

    assign bus.entry_grant   = r_grant;
    assign bus.entry_deny    = r_deny;
    assign bus.exit_ack      = r_ack;
    assign bus.exit_err      = r_err;
    assign bus.uni_parked    = r_uni;
    assign bus.gen_parked    = r_gen;
    assign bus.uni_free      = (r_uni_cap > r_uni) ? r_uni_cap - r_uni : '0;
    assign bus.gen_free      = (r_gen_cap > r_gen) ? r_gen_cap - r_gen : '0;
    assign bus.uni_has_space = (r_uni_cap > r_uni);
    assign bus.gen_has_space = (r_gen_cap > r_gen);
    assign bus.over_capacity = (r_gen > r_gen_cap) || (r_uni > r_uni_cap);
    assign bus.hour          = r_hour;
endmodule
